uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- Frame parser directly downstream of the UART receive FIFO; it pops bytes from the FIFO's read port.
- Decodes a simple boot protocol and issues 32-bit memory writes on a valid/ready port.
- Signals a jump request to the boot/reset logic.
- Used as the serial program loader for TCORE.

Parameters:
- XLEN, 32, address width (matches tcore_param).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1_000_000, inter-byte timeout in clk_i cycles (used only with the optional feature).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  loader enable
- rx_dout_i  in  8  FIFO read data, valid the cycle after rx_re_o
- rx_empty_i  in  1  FIFO empty
- rx_re_o  out  1  FIFO pop strobe
- mem_valid_o  out  1  write request
- mem_ready_i  in  1  write accepted
- mem_addr_o  out  XLEN  word-aligned write address
- mem_wdata_o  out  32  write data, little-endian lanes
- mem_wstrb_o  out  4  byte enables
- boot_req_o  out  1  one-cycle jump pulse
- boot_addr_o  out  XLEN  jump target, held until next jump
- done_o  out  1  one-cycle pulse on good write frame
- err_o  out  1  sticky frame error
- busy_o  out  1  high in any state except SYNC

Behaviour:
- Reset (rst_i=1, sampled on clk_i): all outputs 0, FSM in SYNC; asserting reset mid-frame aborts the frame and drops any pending write.
- Frame format: SYNC_BYTE, CMD, ADDR[4] (LE), LEN[2] (LE, byte count), DATA[LEN], CSUM.
  - CMD 8'h01 = write; CMD 8'h02 = jump.
  - Valid frame: the 8-bit sum of CMD..CSUM equals 8'h00.
- Byte fetch:
  - rx_re_o pulses for one cycle when en_i=1, !rx_empty_i, no read pending and the FSM is not in WRITE.
  - The byte is captured the following cycle (byte_valid).
  - Maximum rate is 1 byte per 2 cycles.
- FSM states: SYNC, CMD, ADDR, LEN, DATA, WRITE, CSUM.
  - SYNC: discard bytes until SYNC_BYTE; accepting it clears err_o and resets the checksum and counters.
  - CMD: 01/02 go to ADDR; any other value sets err_o and returns to SYNC.
  - ADDR: 4 bytes. LEN: 2 bytes.
  - After LEN: write with LEN=0 goes to CSUM; write with LEN>0 goes to DATA; jump with LEN=0 goes to CSUM; jump with LEN!=0 sets err_o and returns to SYNC.
  - DATA:
    - Lane pointer starts at addr[1:0]; each byte goes to lane k with wstrb[k] set.
    - On lane 3 or the last byte, enter WRITE.
  - WRITE:
    - mem_valid_o=1 with addr/wdata/wstrb stable until mem_ready_i=1.
    - On acceptance: word address += 4, clear wstrb, lane pointer to 0; go to DATA if bytes remain, else CSUM.
  - CSUM:
    - Sum==0 and write: done_o pulse.
    - Sum==0 and jump: boot_addr_o<=addr, boot_req_o pulse.
    - Sum!=0: err_o=1, no pulse.
    - Then return to SYNC.
- Checksum rule: writes are committed before CSUM arrives. A checksum error reports the frame bad; it does not roll back memory.
- en_i deasserted mid-frame:
  - No further pops.
  - A pending WRITE completes its handshake.
  - Then return to SYNC without setting err_o.
- Counters: the LEN down-counter is 16-bit; the address increments wrap modulo 2^XLEN.

Optional Feature:
- UART_LOADER_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in CMD/ADDR/LEN/DATA/CSUM and resets on each byte_valid.
  - Reaching TIMEOUT_CYC-1 forces SYNC and sets err_o.
  - Frozen in SYNC and WRITE.
- Undefined: no counter; the FSM waits indefinitely; TIMEOUT_CYC is unused.

Decomposition:
- tcore_param gains:
  - loader_state_e (7-state enum).
  - LDR_CMD_WRITE=8'h01 and LDR_CMD_JUMP=8'h02.
  - LDR_SYNC default.
- Sub-module uart_byte_fetch owns the rx_re_o/empty handshake, the pending flag and byte_valid/byte_data; it takes a stall input from the FSM.

Test Plan:
- Aligned write:
  - Stimulus: A5 01 00 10 00 80 04 00 DE AD BE EF 33.
  - Response: one write, addr 0x80001000, wdata 0xEFBEADDE, wstrb 1111; done_o pulse; err_o=0.
- Unaligned write:
  - Stimulus: A5 01 02 00 00 80 03 00 11 22 33 14.
  - Response: write 0x80000000 strb 1100 lanes2/3=11/22; then write 0x80000004 strb 0001 lane0=33; done_o.
- Jump:
  - Stimulus: A5 02 00 00 00 80 00 00 7E.
  - Response: boot_req_o single pulse, boot_addr_o=0x80000000.
- Bad checksum and recovery:
  - Stimulus: previous jump frame with CSUM 7F.
  - Response: err_o=1, no boot_req_o. Then 3 garbage bytes followed by a valid frame: err_o clears at A5, frame executes.
- Backpressure:
  - Stimulus: mem_ready_i low 20 cycles during WRITE with FIFO non-empty.
  - Response: rx_re_o stays 0; mem_addr/wdata/wstrb stable; exactly one write on ready.
- Timeout (macro defined, TIMEOUT_CYC=100):
  - Stimulus: stop after ADDR byte 2.
  - Response: cycle 99 after the last byte → SYNC, err_o=1, busy_o=0.
  - Macro undefined: still busy after 1000 cycles.

Source files
------------

// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_loader_pkg
//  Purpose : Shared types and constants for the UART boot loader: the frame
//            parser state encoding, command codes and a lane-strobe helper.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

   // Frame parser states; SYNC is the idle/hunt state.
   typedef enum logic [2:0] {
      LDR_SYNC  = 3'd0,
      LDR_CMD   = 3'd1,
      LDR_ADDR  = 3'd2,
      LDR_LEN   = 3'd3,
      LDR_DATA  = 3'd4,
      LDR_WRITE = 3'd5,
      LDR_CSUM  = 3'd6
   } loader_state_e;

   localparam loader_state_e LDR_STATE_RESET = LDR_SYNC;

   localparam logic [7:0] LDR_CMD_WRITE = 8'h01;
   localparam logic [7:0] LDR_CMD_JUMP  = 8'h02;

   // One-hot byte enable for a lane index.
   function automatic logic [3:0] lane_strb(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage : uart_loader_pkg
`default_nettype wire

// File: rtl/uart_loader_byte_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : uart_byte_fetch
//  Purpose : Pops bytes from the UART receive FIFO. One pop is outstanding at
//            most, so the peak rate is one byte every two cycles. The FIFO
//            presents read data the cycle after the pop; that cycle is
//            flagged with byte_valid_o and the data passed straight through.
//  Ports   : clk_i, rst_i     - clock, synchronous active-high reset
//            en_i             - fetch enable
//            stall_i          - parser cannot accept a byte (write in flight)
//            rx_empty_i       - FIFO empty
//            rx_dout_i        - FIFO read data
//            rx_re_o          - FIFO pop strobe
//            byte_valid_o     - byte_data_o carries a fresh byte this cycle
//            byte_data_o      - fetched byte
//  Revision: 1.0 - initial release
// ============================================================================
module uart_byte_fetch (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       stall_i,
   input  logic       rx_empty_i,
   input  logic [7:0] rx_dout_i,
   output logic       rx_re_o,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o
);

   logic pending_q;
   logic pending_d;

   always_comb begin
      rx_re_o   = !rst_i && en_i && !rx_empty_i && !pending_q && !stall_i;
      pending_d = rx_re_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign byte_valid_o = pending_q;
   assign byte_data_o  = rx_dout_i;

endmodule : uart_byte_fetch
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
//  Module  : uart_loader
//  Purpose : Serial program loader. Parses boot frames
//              SYNC_BYTE, CMD, ADDR[4] LE, LEN[2] LE, DATA[LEN], CSUM
//            from the UART receive FIFO, issues 32-bit memory writes and
//            requests a jump. The 8-bit sum of CMD..CSUM must be zero.
//            Writes are committed as data arrives; a bad checksum only
//            flags the frame.
//  Option  : `define UART_LOADER_TIMEOUT_EN enables an inter-byte timeout of
//            TIMEOUT_CYC cycles that aborts the frame with err_o.
//  Ports   : clk_i, rst_i           - clock, synchronous active-high reset
//            en_i                   - loader enable
//            rx_dout_i/rx_empty_i/rx_re_o - FIFO read port
//            mem_valid_o/mem_ready_i/mem_addr_o/mem_wdata_o/mem_wstrb_o
//                                   - memory write request port
//            boot_req_o/boot_addr_o - jump pulse and held jump target
//            done_o                 - pulse on a good write frame
//            err_o                  - sticky frame error
//            busy_o                 - frame in progress
//  Revision: 1.0 - initial release
// ============================================================================
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int         XLEN        = 32,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic [7:0]      rx_dout_i,
   input  logic            rx_empty_i,
   output logic            rx_re_o,
   output logic            mem_valid_o,
   input  logic            mem_ready_i,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [31:0]     mem_wdata_o,
   output logic [3:0]      mem_wstrb_o,
   output logic            boot_req_o,
   output logic [XLEN-1:0] boot_addr_o,
   output logic            done_o,
   output logic            err_o,
   output logic            busy_o
);

   localparam logic [XLEN-3:0] WORD_ONE = {{(XLEN-3){1'b0}}, 1'b1};

   loader_state_e   state_q, state_d;
   logic            err_q, err_d;
   logic [7:0]      sum_q, sum_d;
   logic [1:0]      idx_q, idx_d;       // byte index inside ADDR / LEN
   logic [XLEN-1:0] addr_q, addr_d;
   logic [15:0]     len_q, len_d;       // bytes of DATA still to come
   logic [1:0]      lane_q, lane_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic            is_jump_q, is_jump_d;
   logic            done_q, done_d;
   logic            boot_req_q, boot_req_d;
   logic [XLEN-1:0] boot_addr_q, boot_addr_d;

   logic            byte_valid;
   logic [7:0]      byte_data;
   logic            stall;
   logic            active;
   logic            tmo_hit;
   logic [7:0]      byte_sum;
   logic [15:0]     len_full;
   logic [31:0]     addr32;
   logic [31:0]     addr_shift;

   // ------------------------------------------------------------------------
   // FIFO pop handshake
   // ------------------------------------------------------------------------
   assign stall = (state_q == LDR_WRITE);

   uart_byte_fetch u_fetch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_i         (en_i),
      .stall_i      (stall),
      .rx_empty_i   (rx_empty_i),
      .rx_dout_i    (rx_dout_i),
      .rx_re_o      (rx_re_o),
      .byte_valid_o (byte_valid),
      .byte_data_o  (byte_data)
   );

   // States in which the frame is waiting on the next byte.
   assign active = (state_q == LDR_CMD)  || (state_q == LDR_ADDR) ||
                   (state_q == LDR_LEN)  || (state_q == LDR_DATA) ||
                   (state_q == LDR_CSUM);

   assign byte_sum   = sum_q + byte_data;
   assign len_full   = {byte_data, len_q[15:8]};
   assign addr32     = 32'(addr_q);
   // Address bytes arrive LSB first: shift in from the top.
   assign addr_shift = {byte_data, addr32[31:8]};

   // ------------------------------------------------------------------------
   // Optional inter-byte timeout
   // ------------------------------------------------------------------------
`ifdef UART_LOADER_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = tmo_q;
      if (byte_valid) begin
         tmo_d = 32'd0;
      end else if (active) begin
         tmo_d = tmo_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_q <= 32'd0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign tmo_hit = en_i && active && !byte_valid &&
                    (tmo_q == 32'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Frame parser next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      sum_d       = sum_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      len_d       = len_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      is_jump_d   = is_jump_q;
      done_d      = 1'b0;
      boot_req_d  = 1'b0;
      boot_addr_d = boot_addr_q;

      if (!en_i && (state_q != LDR_WRITE) && (state_q != LDR_SYNC)) begin
         // Disable abandons the frame quietly; a write in flight is
         // allowed to finish first (handled in WRITE).
         state_d = LDR_SYNC;
      end else begin
         unique case (state_q)
            LDR_SYNC: begin
               if (byte_valid && en_i && (byte_data == SYNC_BYTE)) begin
                  state_d = LDR_CMD;
                  err_d   = 1'b0;
                  sum_d   = 8'h00;
                  idx_d   = 2'd0;
                  len_d   = 16'd0;
                  lane_d  = 2'd0;
                  wdata_d = 32'd0;
                  wstrb_d = 4'd0;
               end
            end

            LDR_CMD: begin
               if (byte_valid) begin
                  sum_d = byte_sum;
                  if ((byte_data == LDR_CMD_WRITE) || (byte_data == LDR_CMD_JUMP)) begin
                     is_jump_d = (byte_data == LDR_CMD_JUMP);
                     idx_d     = 2'd0;
                     state_d   = LDR_ADDR;
                  end else begin
                     err_d   = 1'b1;
                     state_d = LDR_SYNC;
                  end
               end
            end

            LDR_ADDR: begin
               if (byte_valid) begin
                  sum_d  = byte_sum;
                  addr_d = XLEN'(addr_shift);
                  idx_d  = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     idx_d   = 2'd0;
                     state_d = LDR_LEN;
                  end
               end
            end

            LDR_LEN: begin
               if (byte_valid) begin
                  sum_d = byte_sum;
                  len_d = len_full;
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd1) begin
                     idx_d = 2'd0;
                     if (len_full == 16'd0) begin
                        state_d = LDR_CSUM;
                     end else if (is_jump_q) begin
                        err_d   = 1'b1;
                        state_d = LDR_SYNC;
                     end else begin
                        // First word may be partial: start at the byte offset.
                        lane_d  = addr_q[1:0];
                        state_d = LDR_DATA;
                     end
                  end
               end
            end

            LDR_DATA: begin
               if (byte_valid) begin
                  sum_d                        = byte_sum;
                  wdata_d[{lane_q, 3'b000} +: 8] = byte_data;
                  wstrb_d                      = wstrb_q | lane_strb(lane_q);
                  len_d                        = len_q - 16'd1;
                  if ((lane_q == 2'd3) || (len_q == 16'd1)) begin
                     state_d = LDR_WRITE;
                  end else begin
                     lane_d = lane_q + 2'd1;
                  end
               end
            end

            LDR_WRITE: begin
               if (mem_ready_i) begin
                  addr_d  = {addr_q[XLEN-1:2] + WORD_ONE, 2'b00};
                  wdata_d = 32'd0;
                  wstrb_d = 4'd0;
                  lane_d  = 2'd0;
                  if (!en_i) begin
                     state_d = LDR_SYNC;
                  end else if (len_q != 16'd0) begin
                     state_d = LDR_DATA;
                  end else begin
                     state_d = LDR_CSUM;
                  end
               end
            end

            LDR_CSUM: begin
               if (byte_valid) begin
                  if (byte_sum == 8'h00) begin
                     if (is_jump_q) begin
                        boot_req_d  = 1'b1;
                        boot_addr_d = addr_q;
                     end else begin
                        done_d = 1'b1;
                     end
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = LDR_SYNC;
               end
            end

            default: begin
               state_d = LDR_SYNC;
            end
         endcase

         if (tmo_hit) begin
            state_d = LDR_SYNC;
            err_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= LDR_STATE_RESET;
         err_q       <= 1'b0;
         sum_q       <= 8'h00;
         idx_q       <= 2'd0;
         addr_q      <= '0;
         len_q       <= 16'd0;
         lane_q      <= 2'd0;
         wdata_q     <= 32'd0;
         wstrb_q     <= 4'd0;
         is_jump_q   <= 1'b0;
         done_q      <= 1'b0;
         boot_req_q  <= 1'b0;
         boot_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         is_jump_q   <= is_jump_d;
         done_q      <= done_d;
         boot_req_q  <= boot_req_d;
         boot_addr_q <= boot_addr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign mem_valid_o = (state_q == LDR_WRITE);
   assign mem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
   assign mem_wdata_o = wdata_q;
   assign mem_wstrb_o = wstrb_q;
   assign boot_req_o  = boot_req_q;
   assign boot_addr_o = boot_addr_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != LDR_SYNC);

endmodule : uart_loader
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_uart_loader
//  Purpose : Self-checking bench for uart_loader. A FIFO model feeds frames;
//            a frame-level reference model predicts memory writes, pulses
//            and the error flag.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_uart_loader;

`ifdef UART_LOADER_TIMEOUT_EN
   localparam int TB_TMO = 100;
`else
   localparam int TB_TMO = 1_000_000;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  rx_dout;
   logic        rx_empty;
   logic        rx_re;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        boot_req;
   logic [31:0] boot_addr;
   logic        done;
   logic        err;
   logic        busy;

   uart_loader #(
      .XLEN        (32),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TB_TMO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .rx_dout_i   (rx_dout),
      .rx_empty_i  (rx_empty),
      .rx_re_o     (rx_re),
      .mem_valid_o (mem_valid),
      .mem_ready_i (mem_ready),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_wstrb_o (mem_wstrb),
      .boot_req_o  (boot_req),
      .boot_addr_o (boot_addr),
      .done_o      (done),
      .err_o       (err),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // FIFO model, write monitor, ready generator
   // ------------------------------------------------------------------------
   logic [7:0] fifo[$];
   wr_t        obs[$];
   int         done_cnt = 0;
   int         boot_cnt = 0;
   int         re_viol  = 0;
   bit         bp_hold  = 1'b0;

   initial begin
      rx_empty  = 1'b1;
      rx_dout   = 8'h00;
      mem_ready = 1'b0;
   end

   // Read data appears the cycle after the pop.
   always @(posedge clk) begin
      if (rx_re && fifo.size() > 0) rx_dout <= fifo.pop_front();
   end

   always @(negedge clk) begin
      wr_t w;
      rx_empty = (fifo.size() == 0);
      if (done)     done_cnt++;
      if (boot_req) boot_cnt++;
      if (mem_valid && rx_re) re_viol++;
      mem_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (mem_valid && mem_ready && !rst) begin
         w.addr = mem_addr;
         w.data = mem_wdata & {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                               {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
         w.strb = mem_wstrb;
         obs.push_back(w);
      end
   end

   // ------------------------------------------------------------------------
   // Frame-level reference model
   // ------------------------------------------------------------------------
   logic [7:0]  fbytes[$];
   logic [7:0]  payload[$];
   wr_t         exp_wr[$];
   int          exp_done;
   int          exp_boot;
   bit          exp_err       = 1'b0;
   logic [31:0] exp_boot_addr = 32'd0;

   task automatic build_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input int len, input logic [7:0] cerr, input int garbage);
      logic [7:0]  b;
      logic [7:0]  sum;
      logic [31:0] ba;
      wr_t         t;
      fbytes.delete();
      exp_wr.delete();
      exp_done = 0;
      exp_boot = 0;
      for (int g = 0; g < garbage; g++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h5A;
         fbytes.push_back(b);
      end
      fbytes.push_back(8'hA5);
      fbytes.push_back(cmd);
      sum = cmd;
      if (cmd != 8'h01 && cmd != 8'h02) begin
         exp_err = 1'b1;
         return;
      end
      for (int i = 0; i < 4; i++) begin
         b = addr[8*i +: 8];
         fbytes.push_back(b);
         sum = sum + b;
      end
      b = 8'(len);
      fbytes.push_back(b);
      sum = sum + b;
      b = 8'(len >> 8);
      fbytes.push_back(b);
      sum = sum + b;
      if (cmd == 8'h02 && len != 0) begin
         exp_err = 1'b1;
         return;
      end
      for (int i = 0; i < len; i++) begin
         b = (i < payload.size()) ? payload[i] : 8'($urandom_range(0, 255));
         fbytes.push_back(b);
         sum = sum + b;
         // Byte i lands at byte address addr+i; consecutive bytes in the
         // same 32-bit word share one write.
         ba = addr + 32'(i);
         if (exp_wr.size() == 0 || exp_wr[exp_wr.size()-1].addr != {ba[31:2], 2'b00}) begin
            t.addr = {ba[31:2], 2'b00};
            t.data = 32'd0;
            t.strb = 4'd0;
         end else begin
            t = exp_wr.pop_back();
         end
         t.data[8*int'(ba[1:0]) +: 8] = b;
         t.strb[ba[1:0]] = 1'b1;
         exp_wr.push_back(t);
      end
      fbytes.push_back((8'h00 - sum) ^ cerr);
      if (cerr == 8'h00) begin
         exp_err = 1'b0;
         if (cmd == 8'h01) exp_done = 1;
         else begin
            exp_boot      = 1;
            exp_boot_addr = addr;
         end
      end else begin
         exp_err = 1'b1;
      end
   endtask

   task automatic push_frame();
      obs.delete();
      done_cnt = 0;
      boot_cnt = 0;
      foreach (fbytes[i]) fifo.push_back(fbytes[i]);
   endtask

   task automatic wait_idle(input string tag);
      int quiet = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (fifo.size() == 0 && !busy) quiet++;
         else quiet = 0;
         if (quiet >= 4) return;
      end
      check({tag, "_idle_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic compare_frame(input string tag);
      int n;
      check({tag, "_nwr"}, 32'(obs.size()), 32'(exp_wr.size()));
      n = (obs.size() < exp_wr.size()) ? obs.size() : exp_wr.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_addr"}, obs[i].addr, exp_wr[i].addr);
         check({tag, "_strb"}, 32'(obs[i].strb), 32'(exp_wr[i].strb));
         check({tag, "_data"}, obs[i].data, exp_wr[i].data);
      end
      check({tag, "_done"},  32'(done_cnt), 32'(exp_done));
      check({tag, "_boot"},  32'(boot_cnt), 32'(exp_boot));
      check({tag, "_baddr"}, boot_addr, exp_boot_addr);
      check({tag, "_err"},   32'(err), 32'(exp_err));
   endtask

   task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                            input int len, input logic [7:0] cerr, input int garbage);
      build_frame(cmd, addr, len, cerr, garbage);
      push_frame();
      wait_idle(tag);
      compare_frame(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      fifo.delete();
      check({tag, "_flags"}, {26'd0, rx_re, mem_valid, boot_req, done, err, busy}, 32'd0);
      check({tag, "_maddr"}, mem_addr, 32'd0);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
      check({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
      check({tag, "_baddr"}, boot_addr, 32'd0);
      exp_err       = 1'b0;
      exp_boot_addr = 32'd0;
      rst = 1'b0;
      obs.delete();
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      logic [31:0] a0, d0;
      logic [3:0]  s0;
      int          r;
      int          len;
      logic [7:0]  cmd;
      logic [7:0]  cerr;

      rst = 1'b1;
      en  = 1'b1;
      do_reset("reset");

      // Aligned write
      payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_frame("aligned", 8'h01, 32'h8000_1000, 4, 8'h00, 0);
      if (obs.size() == 1) begin
         check("aligned_lit_addr", obs[0].addr, 32'h8000_1000);
         check("aligned_lit_data", obs[0].data, 32'hEFBE_ADDE);
         check("aligned_lit_strb", 32'(obs[0].strb), 32'hF);
      end

      // Unaligned write spanning two words
      payload = '{8'h11, 8'h22, 8'h33};
      run_frame("unaligned", 8'h01, 32'h8000_0002, 3, 8'h00, 0);
      if (obs.size() == 2) begin
         check("unal_lit_a0", obs[0].addr, 32'h8000_0000);
         check("unal_lit_s0", 32'(obs[0].strb), 32'hC);
         check("unal_lit_d0", obs[0].data, 32'h2211_0000);
         check("unal_lit_a1", obs[1].addr, 32'h8000_0004);
         check("unal_lit_s1", 32'(obs[1].strb), 32'h1);
         check("unal_lit_d1", obs[1].data, 32'h0000_0033);
      end

      // Jump, then the same frame with a bad checksum (7E -> 7F)
      payload.delete();
      run_frame("jump", 8'h02, 32'h8000_0000, 0, 8'h00, 0);
      check("jump_lit_baddr", boot_addr, 32'h8000_0000);
      run_frame("badcsum", 8'h02, 32'h8000_0000, 0, 8'h01, 0);
      check("badcsum_lit_err", 32'(err), 32'd1);

      // Garbage alone keeps the sticky error; a good frame clears it
      fbytes = '{8'h13, 8'h00, 8'hFF};
      push_frame();
      wait_idle("garbage");
      check("garbage_err_held", 32'(err), 32'd1);
      payload = '{8'h01, 8'h02};
      run_frame("recover", 8'h01, 32'h0000_0040, 2, 8'h00, 3);

      // Write of zero bytes, write wrapping the address space, bad command,
      // jump with nonzero length
      run_frame("len0", 8'h01, 32'h1234_5678, 0, 8'h00, 0);
      payload.delete();
      run_frame("wrap", 8'h01, 32'hFFFF_FFFE, 4, 8'h00, 0);
      run_frame("badcmd", 8'h07, 32'h0, 0, 8'h00, 0);
      run_frame("jumplen", 8'h02, 32'h0000_1000, 3, 8'h00, 0);

      // Backpressure: ready held low for 20 cycles during the first WRITE
      bp_hold = 1'b1;
      fork
         run_frame("bp", 8'h01, 32'h2000_0000, 8, 8'h00, 0);
         begin
            for (int c = 0; c < 2000 && !mem_valid; c++) @(negedge clk);
            check("bp_valid_seen", 32'(mem_valid), 32'd1);
            a0 = mem_addr;
            d0 = mem_wdata;
            s0 = mem_wstrb;
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               check("bp_no_pop", 32'(rx_re), 32'd0);
               check("bp_stable", 32'(mem_valid && mem_addr == a0 && mem_wdata == d0 && mem_wstrb == s0), 32'd1);
            end
            check("bp_no_write_yet", 32'(obs.size()), 32'd0);
            bp_hold = 1'b0;
         end
      join

      // Disable during a held write: the write completes, no error, no done
      bp_hold = 1'b1;
      build_frame(8'h01, 32'h3000_0000, 8, 8'h00, 0);
      push_frame();
      for (int c = 0; c < 2000 && !mem_valid; c++) @(negedge clk);
      check("endrop_valid_seen", 32'(mem_valid), 32'd1);
      en = 1'b0;
      bp_hold = 1'b0;
      for (int c = 0; c < 200 && busy; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("endrop_busy", 32'(busy), 32'd0);
      check("endrop_nwr", 32'(obs.size()), 32'd1);
      if (obs.size() >= 1) check("endrop_data", obs[0].data, exp_wr[0].data);
      check("endrop_done", 32'(done_cnt), 32'd0);
      check("endrop_err", 32'(err), 32'd0);
      fifo.delete();
      en = 1'b1;
      exp_err = 1'b0;

      // Reset in the middle of a frame
      fbytes = '{8'hA5, 8'h01, 8'h00};
      push_frame();
      repeat (12) @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd1);
      do_reset("midrst");

      // Stalled frame: timeout when enabled, otherwise waits forever
      fbytes = '{8'hA5, 8'h01, 8'h00, 8'h10};
      push_frame();
      repeat (60) @(negedge clk);
      check("stall_busy_early", 32'(busy), 32'd1);
`ifdef UART_LOADER_TIMEOUT_EN
      repeat (100) @(negedge clk);
      check("tmo_busy", 32'(busy), 32'd0);
      check("tmo_err", 32'(err), 32'd1);
      exp_err = 1'b1;
`else
      repeat (1000) @(negedge clk);
      check("notmo_busy", 32'(busy), 32'd1);
      check("notmo_err", 32'(err), 32'd0);
      en = 1'b0;
      repeat (4) @(negedge clk);
      check("notmo_abort", 32'(busy), 32'd0);
      en = 1'b1;
`endif

      // Randomized frames
      payload.delete();
      for (int f = 0; f < 40; f++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            cmd = 8'($urandom_range(3, 255));
         end else if (r < 6) begin
            cmd = 8'h02;
         end else begin
            cmd = 8'h01;
         end
         if (cmd == 8'h01) len = $urandom_range(0, 10);
         else if (cmd == 8'h02 && r == 1) len = $urandom_range(1, 5);
         else len = 0;
         cerr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_frame("rand", cmd, $urandom, len, cerr, $urandom_range(0, 2));
      end

      check("re_during_write", 32'(re_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_loader
`default_nettype wire
